ex_mem_stage: RTL and testbench

//  EX->MEM pipeline register. Decodes load/store ops into byte-lane memory requests and flags misaligned accesses.

---
 rtl/ex_mem_stage.sv | 158 +++++++++++++++
 tb/tb_ex_mem_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: decodes load/store ops into byte-lane memory requests,
// flags misaligned accesses, and freezes while a memory access is outstanding.
module ex_mem_stage #(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 4,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_W-1:0]       ex_memOp,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic [ADDR_W-1:0]     ex_memAddr,
  input  logic [REG_ADDR_W-1:0] ex_regDest,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_ack,
  output logic                  mem_memWriteEnable,
  output logic                  mem_memReadEnable,
  output logic [ADDR_W-3:0]     mem_memAddr,
  output logic [3:0]            mem_memSel,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_loadType,
  output logic [DATA_W-1:0]     mem_result,
  output logic [REG_ADDR_W-1:0] mem_regDest,
  output logic                  mem_resultSel,
  output logic                  mem_excMisalign,
  output logic                  stall_req
);

  localparam logic [OP_W-1:0] OP_WREG = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LB   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LBU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LH   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LHU  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SB   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SH   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(9);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  typedef struct packed {
    logic                  we;
    logic                  re;
    logic [ADDR_W-3:0]     addr;
    logic [3:0]            sel;
    logic [DATA_W-1:0]     wdata;
    logic [2:0]            lt;
    logic [DATA_W-1:0]     res;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rsel;
    logic                  exc;
  } stage_t;

  state_t  state;
  stage_t  q;
  stage_t  nxt;
  logic    nxt_access;
  logic    is_load;
  logic    is_store;
  logic    misalign;
  size_t   size;
  logic [2:0] lt;
  logic [1:0] a;

  assign a = ex_memAddr[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_WORD;
    lt       = 3'd0;
    case (ex_memOp)
      OP_LB:   begin is_load  = 1'b1; size = SZ_BYTE; lt = 3'd1; end
      OP_LBU:  begin is_load  = 1'b1; size = SZ_BYTE; lt = 3'd2; end
      OP_LH:   begin is_load  = 1'b1; size = SZ_HALF; lt = 3'd3; end
      OP_LHU:  begin is_load  = 1'b1; size = SZ_HALF; lt = 3'd4; end
      OP_LW:   begin is_load  = 1'b1; size = SZ_WORD; lt = 3'd5; end
      OP_SB:   begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:   begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:   begin is_store = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
  end

  assign misalign = ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'd0));

  // Misaligned loads/stores collapse into a bubble that only carries the exception pulse.
  always_comb begin
    nxt        = '0;
    nxt_access = 1'b0;
    if (ex_memOp == OP_WREG) begin
      nxt.res = ex_result;
      nxt.rd  = ex_regDest;
    end else if (is_load || is_store) begin
      if (misalign) begin
        nxt.exc = 1'b1;
      end else begin
        nxt_access = 1'b1;
        nxt.addr   = ex_memAddr[ADDR_W-1:2];
        case (size)
          SZ_BYTE: nxt.sel = 4'b0001 << a;
          SZ_HALF: nxt.sel = 4'b0011 << a;
          default: nxt.sel = 4'b1111;
        endcase
        if (is_load) begin
          nxt.re   = 1'b1;
          nxt.rsel = 1'b1;
          nxt.rd   = ex_regDest;
          nxt.lt   = lt;
        end else begin
          nxt.we = 1'b1;
          case (size)
            SZ_BYTE: nxt.wdata = {4{ex_result[7:0]}};
            SZ_HALF: nxt.wdata = {2{ex_result[15:0]}};
            default: nxt.wdata = ex_result;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q     <= '0;
      state <= IDLE;
    end else if (state == WAIT && !mem_ack) begin
      q.exc <= 1'b0;
    end else if (state == WAIT && stall) begin
      // Access completed but the pipe is held: retire the request, keep the rest for MEM.
      q.we  <= 1'b0;
      q.re  <= 1'b0;
      q.sel <= '0;
      q.exc <= 1'b0;
      state <= IDLE;
    end else if (stall) begin
      q.exc <= 1'b0;
    end else begin
      q     <= nxt;
      state <= nxt_access ? WAIT : IDLE;
    end
  end

  assign mem_memWriteEnable = q.we;
  assign mem_memReadEnable  = q.re;
  assign mem_memAddr        = q.addr;
  assign mem_memSel         = q.sel;
  assign mem_wdata          = q.wdata;
  assign mem_loadType       = q.lt;
  assign mem_result         = q.res;
  assign mem_regDest        = q.rd;
  assign mem_resultSel      = q.rsel;
  assign mem_excMisalign    = q.exc;
  assign stall_req          = (state == WAIT) && !mem_ack;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed cycles push expected outputs, a monitor pops and compares.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ex_memOp;
  logic [31:0] ex_result;
  logic [31:0] ex_memAddr;
  logic [4:0]  ex_regDest;
  logic        stall, flush, mem_ack;
  logic        mem_memWriteEnable, mem_memReadEnable;
  logic [29:0] mem_memAddr;
  logic [3:0]  mem_memSel;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_loadType;
  logic [31:0] mem_result;
  logic [4:0]  mem_regDest;
  logic        mem_resultSel, mem_excMisalign, stall_req;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [2:0]  lt;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rsel;
    logic        exc;
  } out_t;

  typedef struct packed {
    logic sr;
    out_t o;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  ex_mem_stage #(.ADDR_W(32), .REG_ADDR_W(5), .OP_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ex_memOp(ex_memOp), .ex_result(ex_result),
    .ex_memAddr(ex_memAddr), .ex_regDest(ex_regDest), .stall(stall), .flush(flush),
    .mem_ack(mem_ack), .mem_memWriteEnable(mem_memWriteEnable),
    .mem_memReadEnable(mem_memReadEnable), .mem_memAddr(mem_memAddr),
    .mem_memSel(mem_memSel), .mem_wdata(mem_wdata), .mem_loadType(mem_loadType),
    .mem_result(mem_result), .mem_regDest(mem_regDest), .mem_resultSel(mem_resultSel),
    .mem_excMisalign(mem_excMisalign), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(logic we, logic re, logic [29:0] addr, logic [3:0] sel,
                              logic [31:0] wdata, logic [2:0] lt, logic [31:0] res,
                              logic [4:0] rd, logic rsel, logic exc);
    mk = '{we, re, addr, sel, wdata, lt, res, rd, rsel, exc};
  endfunction

  // One cycle: drive inputs after negedge, queue the stall_req expected before the edge
  // and the registered outputs expected after it.
  task automatic cyc(input logic r, input logic [3:0] op, input logic [31:0] res,
                     input logic [31:0] addr, input logic [4:0] rd, input logic st,
                     input logic fl, input logic ack, input logic exp_sr, input out_t exp_o);
    @(negedge clk);
    #1;
    rst = r; ex_memOp = op; ex_result = res; ex_memAddr = addr; ex_regDest = rd;
    stall = st; flush = fl; mem_ack = ack;
    exp_q.push_back('{exp_sr, exp_o});
  endtask

  initial begin : monitor
    logic sr_s;
    out_t act;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      sr_s = stall_req;
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = {mem_memWriteEnable, mem_memReadEnable, mem_memAddr, mem_memSel, mem_wdata,
               mem_loadType, mem_result, mem_regDest, mem_resultSel, mem_excMisalign};
        n_checks++;
        if (act !== e.o) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %h expected %h", cyc_no, act, e.o);
        end
        n_checks++;
        if (sr_s !== e.sr) begin
          n_fail++;
          $display("FAIL stall_req cycle %0d: got %b expected %b", cyc_no, sr_s, e.sr);
        end
      end
    end
  end

  initial begin : stim
    out_t z;
    z = '0;
    rst = 1'b1; ex_memOp = '0; ex_result = '0; ex_memAddr = '0; ex_regDest = '0;
    stall = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, z);
    // WREG
    cyc(0, 1, 32'hDEADBEEF, 0, 5, 0, 0, 0, 0, mk(0,0,0,0,0,0,32'hDEADBEEF,5,0,0));
    // SB 0x1003, ack held low for 3 cycles (one with stall also set)
    cyc(0, 7, 32'h000000A5, 32'h1003, 7, 0, 0, 0, 0, mk(1,0,30'h400,4'b1000,32'hA5A5A5A5,0,0,0,0,0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, mk(1,0,30'h400,4'b1000,32'hA5A5A5A5,0,0,0,0,0));
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, mk(1,0,30'h400,4'b1000,32'hA5A5A5A5,0,0,0,0,0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, mk(1,0,30'h400,4'b1000,32'hA5A5A5A5,0,0,0,0,0));
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, z);
    // misaligned LH pulses exc for one cycle
    cyc(0, 4, 0, 32'h2001, 3, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, z);
    // LW then flush before ack
    cyc(0, 6, 0, 32'h3000, 9, 0, 0, 0, 0, mk(0,1,30'hC00,4'b1111,0,5,0,9,1,0));
    cyc(0, 1, 32'h12345678, 0, 4, 0, 1, 0, 1, z);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, z);
    // LW acked under stall: request retires, regDest/loadType held, no re-issue
    cyc(0, 6, 0, 32'h44, 12, 0, 0, 0, 0, mk(0,1,30'h11,4'b1111,0,5,0,12,1,0));
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, mk(0,0,30'h11,4'b0000,0,5,0,12,1,0));
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, mk(0,0,30'h11,4'b0000,0,5,0,12,1,0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, z);
    // back-to-back: LHU, SH captured on ack edge, LBU captured on next ack edge
    cyc(0, 5, 0, 32'h2002, 4, 0, 0, 0, 0, mk(0,1,30'h800,4'b1100,0,4,0,4,1,0));
    cyc(0, 8, 32'h1234ABCD, 32'h10, 6, 0, 0, 1, 0, mk(1,0,30'h4,4'b0011,32'hABCDABCD,0,0,0,0,0));
    cyc(0, 3, 0, 32'h5, 6, 0, 0, 1, 0, mk(0,1,30'h1,4'b0010,0,2,0,6,1,0));
    // reset mid-WAIT, then SW issues normally
    cyc(1, 9, 32'h11111111, 32'h40, 1, 0, 0, 0, 1, z);
    cyc(0, 9, 32'hCAFEF00D, 32'h20, 8, 0, 0, 0, 0, mk(1,0,30'h8,4'b1111,32'hCAFEF00D,0,0,0,0,0));
    cyc(0, 2, 0, 32'h7, 2, 0, 0, 1, 0, mk(0,1,30'h1,4'b1000,0,1,0,2,1,0));
    // misaligned SW, then stall in IDLE clears the exc pulse without capturing
    cyc(0, 9, 32'h55, 32'h22, 1, 0, 0, 1, 0, mk(0,0,0,0,0,0,0,0,0,1));
    cyc(0, 1, 32'h99, 0, 3, 1, 0, 0, 0, z);
    // WREG then an unused op code behaves as NOP
    cyc(0, 1, 32'h11, 0, 1, 0, 0, 0, 0, mk(0,0,0,0,0,0,32'h11,1,0,0));
    cyc(0, 12, 32'hFFFF, 32'h8, 3, 0, 0, 0, 0, z);

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
